// File: rtl/div_pkg.sv
// div_pkg: shared FSM state encoding and two's-complement helpers for seq_divider
package div_pkg;
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ITER    = 2'd1;
  localparam logic [1:0] CORRECT = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;
  // Helpers work on a wide container; callers zero-extend in and truncate out,
  // which yields the correct WIDTH-bit two's-complement result.
  localparam int MAX_W = 128;
  function automatic logic [MAX_W-1:0] neg_w(input logic [MAX_W-1:0] x);
    return -x;
  endfunction
  // s is the operand's sign bit (already gated by signed mode).
  function automatic logic [MAX_W-1:0] abs_w(input logic [MAX_W-1:0] x, input logic s);
    return s ? neg_w(x) : x;
  endfunction
endpackage

// File: rtl/nr_addsub_step.sv
// nr_addsub_step: one non-restoring step, a_next = sub ? a-m : a+m, q_bit = ~sign(a_next)
//   a, m   : WIDTH+1-bit partial remainder and divisor magnitude
//   sub    : 1 subtracts (previous remainder non-negative), 0 adds
//   a_next : updated partial remainder; q_bit : quotient bit for this step
module nr_addsub_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0] a,
  input  logic [WIDTH:0] m,
  input  logic           sub,
  output logic [WIDTH:0] a_next,
  output logic           q_bit
);
  always_comb begin
    a_next = sub ? a - m : a + m;
    q_bit  = ~a_next[WIDTH];
  end
endmodule

// File: rtl/seq_divider.sv
// seq_divider: radix-2 non-restoring divider with signed/unsigned mode and start/busy/done handshake
//   clk, rst_b            : clock, asynchronous active-low reset
//   start, signed_mode    : request and operand mode, sampled in IDLE or DONE
//   dividend, divisor     : operands, sampled with start
//   busy, done            : busy through ITER/CORRECT, done pulses one cycle in DONE
//   quotient, remainder   : results, held until the next accepted start
//   div_by_zero, overflow : divisor==0 and signed MIN/-1 flags, valid with done
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   a, m, a_op, a_step;
  logic [WIDTH-1:0] q, dd_mag, dv_mag, q_fix, r_mag, r_fix;
  logic             neg_q, neg_r, q_bit, accept, zero_in, ovf_in, dd_s, dv_s;
  always_comb begin
    accept  = start && (state == IDLE || state == DONE);
    zero_in = divisor == '0;
    ovf_in  = signed_mode && dividend == MIN && divisor == '1;
    dd_s    = signed_mode & dividend[WIDTH-1];
    dv_s    = signed_mode & divisor[WIDTH-1];
    dd_mag  = WIDTH'(abs_w(MAX_W'(dividend), dd_s));
    dv_mag  = WIDTH'(abs_w(MAX_W'(divisor), dv_s));
    // The step unit shifts {A,Q} during ITER and does the restoring add in CORRECT.
    a_op    = (state == ITER) ? {a[WIDTH-1:0], q[WIDTH-1]} : a;
    r_mag   = a[WIDTH] ? a_step[WIDTH-1:0] : a[WIDTH-1:0];
    q_fix   = neg_q ? WIDTH'(neg_w(MAX_W'(q))) : q;
    r_fix   = neg_r ? WIDTH'(neg_w(MAX_W'(r_mag))) : r_mag;
    busy    = state == ITER || state == CORRECT;
    done    = state == DONE;
  end
  nr_addsub_step #(.WIDTH(WIDTH)) u_step (
    .a      (a_op),
    .m      (m),
    .sub    (~a[WIDTH]),
    .a_next (a_step),
    .q_bit  (q_bit)
  );
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state       <= IDLE;
      cnt         <= '0;
      a           <= '0;
      m           <= '0;
      q           <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else if (accept) begin
      div_by_zero <= zero_in;
      overflow    <= !zero_in && ovf_in;
      if (zero_in) begin
        quotient  <= '1;
        remainder <= dividend;
        state     <= DONE;
      end else if (ovf_in) begin
        quotient  <= MIN;
        remainder <= '0;
        state     <= DONE;
      end else begin
        a     <= '0;
        q     <= dd_mag;
        m     <= {1'b0, dv_mag};
        neg_q <= dd_s ^ dv_s;
        neg_r <= dd_s;
        cnt   <= '0;
        state <= ITER;
      end
    end else if (state == ITER) begin
      a     <= a_step;
      q     <= {q[WIDTH-2:0], q_bit};
      cnt   <= cnt + CNT_W'(1);
      state <= (cnt == CNT_W'(WIDTH-1)) ? CORRECT : ITER;
    end else if (state == CORRECT) begin
      quotient  <= q_fix;
      remainder <= r_fix;
      state     <= DONE;
    end else if (state == DONE) begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed self-checking bench for seq_divider at WIDTH=32 and WIDTH=8
module tb_seq_divider;
  logic        clk, rst_b;
  logic        st32, sm32, busy32, done32, dz32, ov32;
  logic [31:0] dd32, dv32, q32, r32;
  logic        st8, sm8, busy8, done8, dz8, ov8;
  logic [7:0]  dd8, dv8, q8, r8;
  int checks = 0, failures = 0;

  seq_divider #(.WIDTH(32)) d32 (
    .clk(clk), .rst_b(rst_b), .start(st32), .signed_mode(sm32), .dividend(dd32), .divisor(dv32),
    .busy(busy32), .done(done32), .quotient(q32), .remainder(r32), .div_by_zero(dz32), .overflow(ov32)
  );
  seq_divider #(.WIDTH(8)) d8 (
    .clk(clk), .rst_b(rst_b), .start(st8), .signed_mode(sm8), .dividend(dd8), .divisor(dv8),
    .busy(busy8), .done(done8), .quotient(q8), .remainder(r8), .div_by_zero(dz8), .overflow(ov8)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic run32(input logic sm, input logic [31:0] dd, input logic [31:0] dv, output int lat, output int bcnt);
    sm32 = sm; dd32 = dd; dv32 = dv; st32 = 1'b1; lat = 0; bcnt = 0;
    do begin
      cyc();
      st32 = 1'b0;
      lat++;
      if (busy32) bcnt++;
    end while (!done32 && lat < 100);
  endtask

  task automatic test_reset();
    rst_b = 1'b0;
    #1;
    checks++;
    if ({busy32, done32, dz32, ov32, q32, r32} !== 68'd0) begin
      failures++;
      $display("FAIL reset32 got busy=%b done=%b dz=%b ov=%b q=%h r=%h want all 0", busy32, done32, dz32, ov32, q32, r32);
    end
    checks++;
    if ({busy8, done8, dz8, ov8, q8, r8} !== 20'd0) begin
      failures++;
      $display("FAIL reset8 got busy=%b done=%b q=%h r=%h want all 0", busy8, done8, q8, r8);
    end
    cyc(); cyc();
    rst_b = 1'b1;
    cyc();
  endtask

  task automatic test_unsigned();
    int lat, bcnt;
    run32(1'b0, 32'd4802, 32'd172, lat, bcnt);
    checks++;
    if ({q32, r32, dz32, ov32} !== {32'd27, 32'd158, 2'b00}) begin
      failures++;
      $display("FAIL unsigned_4802_172 got q=%0d r=%0d dz=%b ov=%b want q=27 r=158 flags 0", q32, r32, dz32, ov32);
    end
    checks++;
    if (lat !== 34) begin
      failures++;
      $display("FAIL latency32 got %0d want 34", lat);
    end
    checks++;
    if (bcnt !== 33) begin
      failures++;
      $display("FAIL busy_cycles32 got %0d want 33", bcnt);
    end
    cyc(); cyc(); cyc();
    checks++;
    if ({done32, busy32, q32, r32} !== {2'b00, 32'd27, 32'd158}) begin
      failures++;
      $display("FAIL hold32 got done=%b busy=%b q=%0d r=%0d want done=0 busy=0 q=27 r=158", done32, busy32, q32, r32);
    end
  endtask

  task automatic test_signed();
    int lat, bcnt;
    run32(1'b1, -32'sd7, 32'd2, lat, bcnt);
    checks++;
    if ({q32, r32, dz32, ov32} !== {32'hFFFFFFFD, 32'hFFFFFFFF, 2'b00}) begin
      failures++;
      $display("FAIL signed_m7_2 got q=%h r=%h dz=%b ov=%b want q=fffffffd r=ffffffff", q32, r32, dz32, ov32);
    end
    run32(1'b1, 32'd7, -32'sd2, lat, bcnt);
    checks++;
    if ({q32, r32} !== {32'hFFFFFFFD, 32'd1}) begin
      failures++;
      $display("FAIL signed_7_m2 got q=%h r=%h want q=fffffffd r=00000001", q32, r32);
    end
    run32(1'b1, -32'sd100, -32'sd7, lat, bcnt);
    checks++;
    if ({q32, r32, lat} !== {32'd14, 32'hFFFFFFFE, 32'd34}) begin
      failures++;
      $display("FAIL signed_m100_m7 got q=%h r=%h lat=%0d want q=0000000e r=fffffffe lat=34", q32, r32, lat);
    end
  endtask

  task automatic test_div_zero();
    int lat, bcnt;
    for (int s = 0; s < 2; s++) begin
      run32(s[0], 32'd100, 32'd0, lat, bcnt);
      checks++;
      if ({q32, r32, dz32, ov32, lat} !== {32'hFFFFFFFF, 32'd100, 2'b10, 32'd1}) begin
        failures++;
        $display("FAIL div_zero mode=%0d got q=%h r=%0d dz=%b ov=%b lat=%0d want q=ffffffff r=100 dz=1 ov=0 lat=1", s, q32, r32, dz32, ov32, lat);
      end
    end
  endtask

  task automatic test_overflow();
    int lat, bcnt;
    run32(1'b1, 32'h80000000, 32'hFFFFFFFF, lat, bcnt);
    checks++;
    if ({q32, r32, dz32, ov32, lat} !== {32'h80000000, 32'd0, 2'b01, 32'd1}) begin
      failures++;
      $display("FAIL overflow_signed got q=%h r=%h dz=%b ov=%b lat=%0d want q=80000000 r=0 ov=1 lat=1", q32, r32, dz32, ov32, lat);
    end
    run32(1'b0, 32'h80000000, 32'hFFFFFFFF, lat, bcnt);
    checks++;
    if ({q32, r32, dz32, ov32, lat} !== {32'd0, 32'h80000000, 2'b00, 32'd34}) begin
      failures++;
      $display("FAIL minus1_unsigned got q=%h r=%h dz=%b ov=%b lat=%0d want q=0 r=80000000 flags 0 lat=34", q32, r32, dz32, ov32, lat);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    sm8 = 1'b0; dd8 = 8'd255; dv8 = 8'd1; st8 = 1'b1; lat = 0;
    do begin
      cyc();
      st8 = 1'b0;
      lat++;
      if (lat == 4) begin
        st8 = 1'b1; dd8 = 8'd10; dv8 = 8'd3;
      end
    end while (!done8 && lat < 100);
    checks++;
    if ({q8, r8, dz8, ov8, lat} !== {8'd255, 8'd0, 2'b00, 32'd10}) begin
      failures++;
      $display("FAIL w8_255_1 got q=%0d r=%0d dz=%b ov=%b lat=%0d want q=255 r=0 lat=10", q8, r8, dz8, ov8, lat);
    end
    dd8 = 8'd200; dv8 = 8'd7; st8 = 1'b1; lat = 0;
    do begin
      cyc();
      st8 = 1'b0;
      lat++;
      if (lat == 1) begin
        checks++;
        if (busy8 !== 1'b1) begin
          failures++;
          $display("FAIL b2b_accept got busy=%b want 1", busy8);
        end
      end
    end while (!done8 && lat < 100);
    checks++;
    if ({q8, r8, lat} !== {8'd28, 8'd4, 32'd10}) begin
      failures++;
      $display("FAIL b2b_200_7 got q=%0d r=%0d lat=%0d want q=28 r=4 lat=10", q8, r8, lat);
    end
  endtask

  task automatic test_reset_mid();
    int lat, bcnt, seen;
    sm32 = 1'b0; dd32 = 32'd1000; dv32 = 32'd3; st32 = 1'b1;
    cyc();
    st32 = 1'b0;
    for (int i = 0; i < 9; i++) cyc();
    rst_b = 1'b0;
    #1;
    checks++;
    if ({busy32, done32, dz32, ov32, q32, r32} !== 68'd0) begin
      failures++;
      $display("FAIL reset_mid got busy=%b done=%b q=%h r=%h want all 0", busy32, done32, q32, r32);
    end
    cyc(); cyc();
    rst_b = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (done32 || busy32) seen++;
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL reset_abort got %0d active cycles want 0", seen);
    end
    run32(1'b0, 32'd1000, 32'd3, lat, bcnt);
    checks++;
    if ({q32, r32, lat} !== {32'd333, 32'd1, 32'd34}) begin
      failures++;
      $display("FAIL after_reset got q=%0d r=%0d lat=%0d want q=333 r=1 lat=34", q32, r32, lat);
    end
  endtask

  initial begin
    clk = 1'b0; rst_b = 1'b0;
    st32 = 1'b0; sm32 = 1'b0; dd32 = '0; dv32 = '0;
    st8 = 1'b0; sm8 = 1'b0; dd8 = '0; dv8 = '0;
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
